// File: rtl/shiftreg_ctrl_pkg.sv
// Shared state encoding and bit-order helper for the shift-register sequencer.
package shiftreg_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Word bit presented at serial position pos (0 = first bit out).
    function automatic int bit_index(input int pos, input int width, input bit msb_first);
        return msb_first ? (width - 1 - pos) : pos;
    endfunction

endpackage

// File: rtl/shiftreg_bit_counter.sv
// Bit counter for the serialiser: counts shifted bits up to WIDTH, flags the last data bit.
module shiftreg_bit_counter #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    // Saturates at WIDTH so the count holds through the parity and done cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_W'(WIDTH))) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shiftreg_seq_ctrl.sv
// Serialises a captured word onto the shift register; SHIFTREG_PARITY_EN appends an even-parity bit.
// States: IDLE wait for word | SHIFT data bits | PARITY parity bit | DONE one-cycle done pulse.
module shiftreg_seq_ctrl
    import shiftreg_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    localparam int CNT_W    = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_abort,
    output logic             o_sr_en,
    output logic             o_sr_in,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_bit_cnt
);

    localparam int IDX_W     = $clog2(WIDTH);
    localparam int FIRST_IDX = bit_index(0, WIDTH, MSB_FIRST != 0);

    state_t           r_state;
    logic [WIDTH-1:0] r_word;
    logic             r_sr_en;
    logic             r_sr_in;
    logic             r_busy;
    logic             r_done;

    logic             w_ready;
    logic             w_accept;
    logic             w_in_word;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_last_bit;
    logic [CNT_W-1:0] w_cnt;
    logic [IDX_W-1:0] w_next_idx;

    assign w_ready    = (r_state == ST_IDLE) && !i_rst;
    assign w_accept   = w_ready && i_in_valid && !i_abort;
    assign w_in_word  = (r_state == ST_SHIFT) || (r_state == ST_PARITY);
    assign w_cnt_clr  = (r_state == ST_DONE) || (w_in_word && i_abort);
    assign w_cnt_inc  = (r_state == ST_SHIFT) && !i_abort;
    assign w_next_idx = IDX_W'(bit_index(int'(w_cnt) + 1, WIDTH, MSB_FIRST != 0));

`ifdef SHIFTREG_PARITY_EN
    logic w_parity;
    assign w_parity = ^r_word;
`endif

    shiftreg_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_cnt_clr),
        .i_inc (w_cnt_inc),
        .o_cnt (w_cnt),
        .o_tc  (w_last_bit)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_sr_en <= 1'b0;
            r_sr_in <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_SHIFT;
                        r_word  <= i_in_data;
                        r_sr_en <= 1'b1;
                        r_sr_in <= i_in_data[FIRST_IDX];
                        r_busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_sr_en <= 1'b0;
                        r_sr_in <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_last_bit) begin
`ifdef SHIFTREG_PARITY_EN
                        r_state <= ST_PARITY;
                        r_sr_in <= w_parity;
`else
                        r_state <= ST_DONE;
                        r_sr_en <= 1'b0;
                        r_sr_in <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_sr_in <= r_word[w_next_idx];
                    end
                end
`ifdef SHIFTREG_PARITY_EN
                ST_PARITY: begin
                    r_sr_en <= 1'b0;
                    r_sr_in <= 1'b0;
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
`endif
                // Abort is deliberately not looked at here: a finished word always reports done.
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_sr_en <= 1'b0;
                    r_sr_in <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready = w_ready;
    assign o_sr_en    = r_sr_en;
    assign o_sr_in    = r_sr_in;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_bit_cnt  = w_cnt;

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Bench for shiftreg_seq_ctrl: an MSB-first and an LSB-first instance share all stimulus.
module tb_shiftreg_seq_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);
    localparam int VW = CW + 5;
`ifdef SHIFTREG_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LAST = W + 2 + PAR;
    localparam logic [VW-1:0] ZERO_VEC = '0;
    localparam logic [VW-1:0] IDLE_VEC = {5'b00001, {CW{1'b0}}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  in_data = '0;

    logic          ready_m, en_m, sin_m, busy_m, done_m;
    logic          ready_l, en_l, sin_l, busy_l, done_l;
    logic [CW-1:0] cnt_m, cnt_l;
    logic [VW-1:0] obs_m, obs_l;

    assign obs_m = {en_m, sin_m, busy_m, done_m, ready_m, cnt_m};
    assign obs_l = {en_l, sin_l, busy_l, done_l, ready_l, cnt_l};

    int n_pass  = 0;
    int n_total = 0;

    shiftreg_seq_ctrl #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .i_clk(clk), .i_rst(rst), .i_in_data(in_data), .i_in_valid(in_valid),
        .o_in_ready(ready_m), .i_abort(abort), .o_sr_en(en_m), .o_sr_in(sin_m),
        .o_busy(busy_m), .o_done(done_m), .o_bit_cnt(cnt_m)
    );

    shiftreg_seq_ctrl #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .i_clk(clk), .i_rst(rst), .i_in_data(in_data), .i_in_valid(in_valid),
        .o_in_ready(ready_l), .i_abort(abort), .o_sr_en(en_l), .o_sr_in(sin_l),
        .o_busy(busy_l), .o_done(done_l), .o_bit_cnt(cnt_l)
    );

    // Expected {sr_en, sr_in, busy, done, in_ready, bit_cnt} k cycles after the capture edge.
    function automatic logic [VW-1:0] expect_at(input logic [W-1:0] d, input bit msb, input int k);
        if (k >= 1 && k <= W)
            return {1'b1, (msb ? d[W-k] : d[k-1]), 3'b100, CW'(k - 1)};
        if (PAR == 1 && k == W + 1)
            return {1'b1, ^d, 3'b100, CW'(W)};
        if (k == W + 1 + PAR)
            return {5'b00110, CW'(W)};
        return IDLE_VEC;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        repeat (2) begin
            @(negedge clk);
            n_total++;
            if (obs_m !== ZERO_VEC) $display("FAIL reset_m got=%h exp=%h", obs_m, ZERO_VEC); else n_pass++;
            n_total++;
            if (obs_l !== ZERO_VEC) $display("FAIL reset_l got=%h exp=%h", obs_l, ZERO_VEC); else n_pass++;
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_total++;
        if (obs_m !== IDLE_VEC) $display("FAIL reset_release got=%h exp=%h", obs_m, IDLE_VEC); else n_pass++;
    endtask

    task automatic test_word_table();
        logic [W-1:0] tbl [4];
        logic [W-1:0] d;
        logic [VW-1:0] e_m, e_l;
        tbl[0] = 8'hB4; tbl[1] = 8'h01; tbl[2] = 8'h07; tbl[3] = 8'h03;
        for (int i = 0; i < 4; i++) begin
            d = tbl[i];
            @(negedge clk); in_data = d; in_valid = 1'b1;
            for (int k = 1; k <= LAST; k++) begin
                @(negedge clk);
                if (k == 1) in_valid = 1'b0;
                e_m = expect_at(d, 1'b1, k); e_l = expect_at(d, 1'b0, k);
                n_total++;
                if (obs_m !== e_m) $display("FAIL table_m d=%h k=%0d got=%h exp=%h", d, k, obs_m, e_m); else n_pass++;
                n_total++;
                if (obs_l !== e_l) $display("FAIL table_l d=%h k=%0d got=%h exp=%h", d, k, obs_l, e_l); else n_pass++;
            end
        end
    endtask

    task automatic test_random_words();
        logic [W-1:0] d;
        logic [VW-1:0] e_m, e_l;
        for (int i = 0; i < 8; i++) begin
            d = W'($urandom);
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                n_total++;
                if (obs_m !== IDLE_VEC) $display("FAIL gap_idle got=%h exp=%h", obs_m, IDLE_VEC); else n_pass++;
            end
            @(negedge clk); in_data = d; in_valid = 1'b1;
            for (int k = 1; k <= LAST; k++) begin
                @(negedge clk);
                if (k == 1) in_valid = 1'b0;
                if (k > 1) in_data = W'($urandom);
                e_m = expect_at(d, 1'b1, k); e_l = expect_at(d, 1'b0, k);
                n_total++;
                if (obs_m !== e_m) $display("FAIL rand_m d=%h k=%0d got=%h exp=%h", d, k, obs_m, e_m); else n_pass++;
                n_total++;
                if (obs_l !== e_l) $display("FAIL rand_l d=%h k=%0d got=%h exp=%h", d, k, obs_l, e_l); else n_pass++;
            end
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] d;
        logic [VW-1:0] e_m;
        d = 8'hFF;
        @(negedge clk); in_data = d; in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            e_m = expect_at(d, 1'b1, k);
            n_total++;
            if (obs_m !== e_m) $display("FAIL abort_pre k=%0d got=%h exp=%h", k, obs_m, e_m); else n_pass++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_total++;
        if (obs_m !== IDLE_VEC) $display("FAIL abort_idle_m got=%h exp=%h", obs_m, IDLE_VEC); else n_pass++;
        n_total++;
        if (obs_l !== IDLE_VEC) $display("FAIL abort_idle_l got=%h exp=%h", obs_l, IDLE_VEC); else n_pass++;
        repeat (W + 2) begin
            @(negedge clk);
            n_total++;
            if (obs_m !== IDLE_VEC) $display("FAIL abort_no_done got=%h exp=%h", obs_m, IDLE_VEC); else n_pass++;
        end
        d = W'($urandom);
        @(negedge clk); in_data = d; in_valid = 1'b1;
        for (int k = 1; k <= LAST; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            e_m = expect_at(d, 1'b1, k);
            n_total++;
            if (obs_m !== e_m) $display("FAIL abort_next d=%h k=%0d got=%h exp=%h", d, k, obs_m, e_m); else n_pass++;
        end
    endtask

    task automatic test_abort_in_done();
        logic [W-1:0] d;
        logic [VW-1:0] e_m;
        d = W'($urandom);
        @(negedge clk); in_data = d; in_valid = 1'b1;
        for (int k = 1; k <= LAST; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            e_m = expect_at(d, 1'b1, k);
            n_total++;
            if (obs_m !== e_m) $display("FAIL abort_done d=%h k=%0d got=%h exp=%h", d, k, obs_m, e_m); else n_pass++;
            abort = (k == W + 1 + PAR);
        end
        abort = 1'b0;
    endtask

    task automatic test_rst_mid_word();
        logic [W-1:0] d;
        logic [VW-1:0] e_m, e_l;
        d = W'($urandom);
        @(negedge clk); in_data = d; in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            e_m = expect_at(d, 1'b1, k);
            n_total++;
            if (obs_m !== e_m) $display("FAIL rst_pre k=%0d got=%h exp=%h", k, obs_m, e_m); else n_pass++;
        end
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (obs_m !== ZERO_VEC) $display("FAIL rst_mid_m got=%h exp=%h", obs_m, ZERO_VEC); else n_pass++;
        n_total++;
        if (obs_l !== ZERO_VEC) $display("FAIL rst_mid_l got=%h exp=%h", obs_l, ZERO_VEC); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (obs_m !== IDLE_VEC) $display("FAIL rst_after got=%h exp=%h", obs_m, IDLE_VEC); else n_pass++;
        d = W'($urandom);
        in_data = d; in_valid = 1'b1; abort = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if (obs_m !== IDLE_VEC) $display("FAIL abort_idle_capture got=%h exp=%h", obs_m, IDLE_VEC); else n_pass++;
        end
        abort = 1'b0;
        for (int k = 1; k <= LAST; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            e_m = expect_at(d, 1'b1, k); e_l = expect_at(d, 1'b0, k);
            n_total++;
            if (obs_m !== e_m) $display("FAIL held_m d=%h k=%0d got=%h exp=%h", d, k, obs_m, e_m); else n_pass++;
            n_total++;
            if (obs_l !== e_l) $display("FAIL held_l d=%h k=%0d got=%h exp=%h", d, k, obs_l, e_l); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d1, d2;
        logic [VW-1:0] e_m, e_l;
        d1 = 8'hA5; d2 = 8'h5A;
        @(negedge clk); in_data = d1; in_valid = 1'b1;
        for (int k = 1; k <= LAST; k++) begin
            @(negedge clk);
            if (k == 3) in_data = d2;
            e_m = expect_at(d1, 1'b1, k); e_l = expect_at(d1, 1'b0, k);
            n_total++;
            if (obs_m !== e_m) $display("FAIL b2b1_m k=%0d got=%h exp=%h", k, obs_m, e_m); else n_pass++;
            n_total++;
            if (obs_l !== e_l) $display("FAIL b2b1_l k=%0d got=%h exp=%h", k, obs_l, e_l); else n_pass++;
        end
        for (int k = 1; k <= LAST; k++) begin
            @(negedge clk);
            if (k == 2) in_data = W'($urandom);
            if (k == W) in_valid = 1'b0;
            e_m = expect_at(d2, 1'b1, k); e_l = expect_at(d2, 1'b0, k);
            n_total++;
            if (obs_m !== e_m) $display("FAIL b2b2_m k=%0d got=%h exp=%h", k, obs_m, e_m); else n_pass++;
            n_total++;
            if (obs_l !== e_l) $display("FAIL b2b2_l k=%0d got=%h exp=%h", k, obs_l, e_l); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_word_table();
        test_random_words();
        test_abort();
        test_abort_in_done();
        test_rst_mid_word();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
